// File: rtl/controller_hub_pkg.sv
// Shared types and layout helpers for the controller hub.
// Field i of every pad bus starts at field_lsb(i).
package controller_hub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    SHIFT,
    COMMIT
  } hub_state_t;

  localparam int FIELD_W = 8;
  localparam int BUS_W   = 2 * FIELD_W;

  function automatic int field_lsb(input int i, input int w = FIELD_W);
    return i * w;
  endfunction

endpackage

// File: rtl/controller_phase_timer_m.sv
// Phase window timer for the pad serial protocol.
// Counts a half-period or full-period window and flags its last cycle.
module controller_phase_timer_m #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic full,
  output logic last
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_END = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running count, zeroed whenever the FSM opens a new window.
  always_ff @(posedge clk) begin
    if (rst || restart) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

  assign last = (cnt == (full ? FULL_END : HALF_END));

endmodule

// File: rtl/controller_hub.sv
// Multi-pad NES-style serial poller with atomic commit
// and sticky pressed flags cleared by CPU read strobes.
module controller_hub
  import controller_hub_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_BUTTONS     = 8,
  parameter int CLK_DIV         = 4
) (
  input  logic                                   cpu_clk,
  input  logic                                   rst,
  input  logic                                   start_fetch,
  output logic                                   controller_latch,
  output logic                                   controller_clk_out,
  input  logic [NUM_CONTROLLERS-1:0]             controller_data_in_B,
  input  logic [NUM_CONTROLLERS-1:0]             clear_pressed,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
  output logic                                   busy,
  output logic                                   fetch_done
);

  localparam int NC = NUM_CONTROLLERS;
  localparam int NB = NUM_BUTTONS;
  localparam int TW = NC * NB;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  hub_state_t state, state_d;

  logic [KW-1:0]        k;
  logic                 k_clr, k_inc;
  logic                 restart, full, last;
  logic                 sample_en, commit;
  logic [NB-1:0]        onehot;
  logic [NC-1:0]        bits;
  logic [NC-1:0][NB-1:0] shift, shift_d;
  logic [TW-1:0]        shift_flat, clr_mask;
  logic [TW-1:0]        buttons, pressed;

  controller_phase_timer_m #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk    (cpu_clk),
    .rst    (rst),
    .restart(restart),
    .full   (full),
    .last   (last)
  );

  assign bits       = ~controller_data_in_B;
  assign onehot     = NB'(1) << k;
  assign shift_flat = shift;

  for (genvar g = 0; g < NC; g++) begin : g_pad
    assign shift_d[g] = sample_en
      ? ((shift[g] & ~onehot) | (bits[g] ? onehot : '0))
      : shift[g];
    assign clr_mask[field_lsb(g, NB) +: NB] = {NB{clear_pressed[g]}};
  end

  // Next-state and per-state strobes of the poll sequence.
  always_comb begin
    state_d   = state;
    restart   = 1'b0;
    full      = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    sample_en = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        restart = 1'b1;
        if (start_fetch) begin
          state_d = LATCH;
          k_clr   = 1'b1;
        end
      end
      LATCH: begin
        full = 1'b1;
        if (last) begin
          state_d = SAMPLE;
          restart = 1'b1;
        end
      end
      SAMPLE: begin
        if (last) begin
          sample_en = 1'b1;
          restart   = 1'b1;
          state_d   = (k == K_LAST) ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_d = SAMPLE;
          restart = 1'b1;
          k_inc   = 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        restart = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bit index, shift data, committed buttons and sticky flags.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      shift   <= '0;
      buttons <= '0;
      pressed <= '0;
    end else begin
      state <= state_d;
      if (k_clr)      k <= '0;
      else if (k_inc) k <= k + KW'(1);
      shift <= shift_d;
      if (commit) buttons <= shift_flat;
      pressed <= (pressed & ~clr_mask)
               | (commit ? (shift_flat & ~buttons) : '0);
    end
  end

  // Pad-facing and status outputs registered from the next state.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      controller_latch   <= 1'b0;
      controller_clk_out <= 1'b0;
      busy               <= 1'b0;
      fetch_done         <= 1'b0;
    end else begin
      controller_latch   <= (state_d == LATCH);
      controller_clk_out <= (state_d == SHIFT);
      busy               <= (state_d != IDLE);
      fetch_done         <= (state_d == COMMIT);
    end
  end

  assign buttons_out = buttons;
  assign pressed_out = pressed;

endmodule

// File: tb/tb_controller_hub.sv
// Directed bench for controller_hub: two instances (2x8 /1 and 4x12 /3)
// driven by behavioural pads, checked against a pushed scoreboard.
module tb_controller_hub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, b_start;
  logic [1:0]  a_din, a_clr;
  logic [3:0]  b_din, b_clr;
  logic        a_latch, a_cko, a_busy, a_done;
  logic        b_latch, b_cko, b_busy, b_done;
  logic [15:0] a_btn, a_prs;
  logic [47:0] b_btn, b_prs;

  controller_hub #(
    .NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .CLK_DIV(1)
  ) dut_a (
    .cpu_clk(clk), .rst(rst), .start_fetch(a_start),
    .controller_latch(a_latch), .controller_clk_out(a_cko),
    .controller_data_in_B(a_din), .clear_pressed(a_clr),
    .buttons_out(a_btn), .pressed_out(a_prs),
    .busy(a_busy), .fetch_done(a_done)
  );

  controller_hub #(
    .NUM_CONTROLLERS(4), .NUM_BUTTONS(12), .CLK_DIV(3)
  ) dut_b (
    .cpu_clk(clk), .rst(rst), .start_fetch(b_start),
    .controller_latch(b_latch), .controller_clk_out(b_cko),
    .controller_data_in_B(b_din), .clear_pressed(b_clr),
    .buttons_out(b_btn), .pressed_out(b_prs),
    .busy(b_busy), .fetch_done(b_done)
  );

  // Behavioural pads: parallel load on latch, advance on clk rise.
  logic [15:0] pat_a [2];
  logic [15:0] pat_b [4];
  logic [4:0]  idx_a = '0, idx_b = '0;
  logic        pa_cko = 1'b0, pb_cko = 1'b0;

  always @(posedge clk) begin
    pa_cko <= a_cko;
    pb_cko <= b_cko;
    if (a_latch) idx_a <= '0;
    else if (a_cko && !pa_cko) idx_a <= idx_a + 5'd1;
    if (b_latch) idx_b <= '0;
    else if (b_cko && !pb_cko) idx_b <= idx_b + 5'd1;
  end

  assign a_din = {~pat_a[1][idx_a[3:0]], ~pat_a[0][idx_a[3:0]]};
  assign b_din = {~pat_b[3][idx_b[3:0]], ~pat_b[2][idx_b[3:0]],
                  ~pat_b[1][idx_b[3:0]], ~pat_b[0][idx_b[3:0]]};

  int errors = 0;
  int checks = 0;
  logic [63:0] q_btn [$];
  logic [63:0] q_prs [$];
  logic [63:0] m_btn [2];
  logic [63:0] m_prs [2];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int dut, input logic v);
    if (dut == 0) a_start = v;
    else          b_start = v;
  endtask

  task automatic set_clr(input int dut, input logic [3:0] v);
    if (dut == 0) a_clr = v[1:0];
    else          b_clr = v;
  endtask

  // One poll: push expectations, run it, verify timing, pop and compare.
  task automatic poll(input int dut, input logic [63:0] pat,
                      input logic [3:0] clr_commit, input bit stray);
    int nc, nb, d, n, done_n, lat_cnt, lat_last, hi, rises, busy_low;
    int bound, extra;
    logic prev, lat, cko, bsy, dn;
    logic [63:0] fmask, cmask, exp_p, obs_b, obs_p;
    nc = (dut == 0) ? 2 : 4;
    nb = (dut == 0) ? 8 : 12;
    d  = (dut == 0) ? 1 : 3;
    fmask = (64'd1 << nb) - 64'd1;
    cmask = '0;
    for (int i = 0; i < nc; i++) begin
      if (dut == 0) pat_a[i] = 16'((pat >> (i * nb)) & fmask);
      else          pat_b[i] = 16'((pat >> (i * nb)) & fmask);
      if (clr_commit[i]) cmask |= fmask << (i * nb);
    end
    exp_p = (m_prs[dut] & ~cmask) | (pat & ~m_btn[dut]);
    q_btn.push_back(pat);
    q_prs.push_back(exp_p);
    m_btn[dut] = pat;
    m_prs[dut] = exp_p;
    set_start(dut, 1'b1);
    @(negedge clk);
    set_start(dut, 1'b0);
    n = 1; done_n = 0; lat_cnt = 0; lat_last = 0;
    hi = 0; rises = 0; busy_low = 0; prev = 1'b0;
    bound = (2 * nb + 1) * d + 6;
    while (n <= bound) begin
      lat = (dut == 0) ? a_latch : b_latch;
      cko = (dut == 0) ? a_cko   : b_cko;
      bsy = (dut == 0) ? a_busy  : b_busy;
      dn  = (dut == 0) ? a_done  : b_done;
      if (lat) begin lat_cnt++; lat_last = n; end
      if (cko) begin hi++; if (!prev) rises++; end
      prev = cko;
      if (!bsy) busy_low++;
      set_start(dut, stray && (n == 3 * d + 1));
      if (dn) begin
        done_n = n;
        set_clr(dut, clr_commit);
        break;
      end
      @(negedge clk);
      n++;
    end
    check("done_cycle", 64'(done_n), 64'((2 * nb + 1) * d + 1));
    check("latch_width", 64'(lat_cnt), 64'(2 * d));
    check("latch_end", 64'(lat_last), 64'(2 * d));
    check("clk_high_cycles", 64'(hi), 64'((nb - 1) * d));
    check("clk_rises", 64'(rises), 64'(nb - 1));
    check("busy_held", 64'(busy_low), 64'd0);
    @(negedge clk);
    set_clr(dut, 4'd0);
    set_start(dut, 1'b0);
    dn  = (dut == 0) ? a_done : b_done;
    bsy = (dut == 0) ? a_busy : b_busy;
    check("done_single_pulse", 64'(dn), 64'd0);
    check("idle_after_commit", 64'(bsy), 64'd0);
    obs_b = (dut == 0) ? 64'(a_btn) : 64'(b_btn);
    obs_p = (dut == 0) ? 64'(a_prs) : 64'(b_prs);
    if (q_btn.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'(q_btn.size()));
    end else begin
      check("buttons", obs_b, q_btn.pop_front());
      check("pressed", obs_p, q_prs.pop_front());
    end
    if (stray) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if ((dut == 0) ? a_done : b_done) extra++;
      end
      check("stray_start_dropped", 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_clr = '0; b_clr = '0;
    for (int i = 0; i < 2; i++) pat_a[i] = '0;
    for (int i = 0; i < 4; i++) pat_b[i] = '0;
    m_btn[0] = '0; m_btn[1] = '0;
    m_prs[0] = '0; m_prs[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_a", {a_btn, a_prs, a_latch, a_cko, a_busy, a_done}, 64'd0);
    check("reset_b", 64'({b_latch, b_cko, b_busy, b_done}), 64'd0);
    check("reset_b_bus", 64'(b_btn | b_prs), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    poll(0, 64'h0F_A5, 4'd0, 1'b0);
    check("tp_buttons", 64'(a_btn), 64'h0FA5);
    check("tp_pressed", 64'(a_prs), 64'h0FA5);

    poll(0, 64'h0F_A7, 4'd0, 1'b0);
    check("repoll_field0", 64'(a_prs[7:0]), 64'hA7);

    a_clr = 2'b01;
    @(negedge clk);
    a_clr = 2'b00;
    m_prs[0] = m_prs[0] & 64'hFF00;
    check("clear_field0", 64'(a_prs), 64'h0F00);

    poll(0, 64'h0F_A5, 4'd0, 1'b0);
    poll(0, 64'h0F_A7, 4'b0001, 1'b0);
    check("clear_vs_set", 64'(a_prs), 64'h0F02);

    poll(0, 64'hF0_3C, 4'd0, 1'b1);

    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs",
          {a_btn, a_prs, a_latch, a_cko, a_busy, a_done}, 64'd0);
    m_btn[0] = '0; m_prs[0] = '0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (a_done) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    poll(0, 64'h0F_A5, 4'd0, 1'b0);

    poll(1, 64'h000_FFF_123_ABC, 4'd0, 1'b0);
    poll(1, 64'h5A5_FFF_123_ABD, 4'b0010, 1'b0);
    check("b_pressed_const", 64'(b_prs), 64'h5A5_FFF_000_ABD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
